proc_selftest_seq: RTL and testbench

- Synthesizable run controller that replaces the hand-written per-program bench sequence for the single-cycle processor.
- Runs NUM_PROGS programs back-to-back. For each program it holds the processor in reset with the program's start PC, releases it, and waits for currentpc to reach the program's end PC.
- At that point it samples dmemout, compares it with the expected value and records pass/fail. A per-program watchdog guards against infinite loops.
- Sits between a top-level/bench start strobe and the processor's resetl/startpc/currentpc/dmemout ports.

---
 rtl/proc_selftest_seq.sv | 133 +++++++++++++
 tb/tb_proc_selftest_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/proc_selftest_seq.sv
// Runs a table of programs on the processor and records pass, fail and timeout for each one.
// One program takes RESET_CYCLES + (k+1) + 2 cycles; abort ends the run through DONE.
module proc_selftest_seq #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int NUM_PROGS    = 2,
  parameter int RESET_CYCLES = 2,
  parameter int WDOG_W       = 16,
  parameter int WDOG_LIMIT   = 255,
  localparam int PROG_W      = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1,
  localparam int CNT_W       = $clog2(NUM_PROGS + 1),
  localparam int RST_W       = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1
) (
  input  logic                          CLK,
  input  logic                          resetl,
  input  logic                          start,
  input  logic                          abort,
  input  logic [NUM_PROGS*ADDR_W-1:0]   start_pcs,
  input  logic [NUM_PROGS*ADDR_W-1:0]   end_pcs,
  input  logic [NUM_PROGS*DATA_W-1:0]   expected,
  input  logic [ADDR_W-1:0]             currentpc,
  input  logic [DATA_W-1:0]             dmemout,
  output logic                          proc_resetl,
  output logic [ADDR_W-1:0]             proc_startpc,
  output logic                          busy,
  output logic                          done,
  output logic [PROG_W-1:0]             cur_prog,
  output logic [NUM_PROGS-1:0]          pass_mask,
  output logic [NUM_PROGS-1:0]          timeout_mask,
  output logic [CNT_W-1:0]              pass_count,
  output logic                          all_passed,
  output logic [DATA_W-1:0]             result
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RESET = 3'd1,
    RUN   = 3'd2,
    CHECK = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t              state, state_n;
  logic [RST_W-1:0]    rst_cnt;
  logic [WDOG_W-1:0]   wdog;

  logic [ADDR_W-1:0]   start_tbl [NUM_PROGS];
  logic [ADDR_W-1:0]   end_tbl   [NUM_PROGS];
  logic [DATA_W-1:0]   exp_tbl   [NUM_PROGS];

  for (genvar i = 0; i < NUM_PROGS; i++) begin : g_tbl
    assign start_tbl[i] = start_pcs[i*ADDR_W +: ADDR_W];
    assign end_tbl[i]   = end_pcs[i*ADDR_W +: ADDR_W];
    assign exp_tbl[i]   = expected[i*DATA_W +: DATA_W];
  end

  logic end_hit, wdog_hit, rst_last, last_prog;
  assign end_hit   = (currentpc >= end_tbl[cur_prog]);
  assign wdog_hit  = (wdog == WDOG_W'(WDOG_LIMIT));
  assign rst_last  = (rst_cnt == RST_W'(RESET_CYCLES - 1));
  assign last_prog = (cur_prog == PROG_W'(NUM_PROGS - 1));

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RESET;
      RESET:   if (abort) state_n = DONE;
               else if (rst_last) state_n = RUN;
      RUN:     if (abort) state_n = DONE;
               else if (end_hit) state_n = CHECK;
               else if (wdog_hit) state_n = NEXT;
      CHECK:   state_n = abort ? DONE : NEXT;
      NEXT:    if (abort || last_prog) state_n = DONE;
               else state_n = RESET;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!resetl) begin
      state        <= IDLE;
      rst_cnt      <= '0;
      wdog         <= '0;
      cur_prog     <= '0;
      pass_mask    <= '0;
      timeout_mask <= '0;
      pass_count   <= '0;
      all_passed   <= 1'b0;
      result       <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (start) begin
          cur_prog     <= '0;
          pass_mask    <= '0;
          timeout_mask <= '0;
          pass_count   <= '0;
          all_passed   <= 1'b0;
        end
        RESET: begin
          wdog    <= '0;
          rst_cnt <= (state_n == RESET) ? rst_cnt + 1'b1 : '0;
        end
        RUN: begin
          wdog <= wdog + 1'b1;
          if (!abort) begin
            if (end_hit)
              result <= dmemout;
            else if (wdog_hit)
              timeout_mask[cur_prog] <= 1'b1;
          end
        end
        CHECK: if (!abort && result == exp_tbl[cur_prog]) begin
          pass_mask[cur_prog] <= 1'b1;
          pass_count          <= pass_count + 1'b1;
        end
        NEXT: if (!abort && !last_prog) cur_prog <= cur_prog + 1'b1;
        default: ;
      endcase
      // Latched on the way into DONE so it is already valid during the done pulse.
      if (state != DONE && state_n == DONE)
        all_passed <= (pass_count == CNT_W'(NUM_PROGS));
    end
  end

  assign proc_resetl  = (state == RUN) || (state == CHECK);
  assign proc_startpc = (state == IDLE || state == DONE) ? '0 : start_tbl[cur_prog];
  assign busy         = (state != IDLE) && (state != DONE);
  assign done         = (state == DONE);

endmodule

// File: tb/tb_proc_selftest_seq.sv
// Directed bench for proc_selftest_seq driving a stub processor that steps its PC by 4 per cycle.
module tb_proc_selftest_seq;

  logic         CLK = 1'b0;
  logic         resetl, start, abort;
  logic [127:0] start_pcs, end_pcs, expected;
  logic [63:0]  currentpc, dmemout;
  logic         proc_resetl, busy, done, all_passed;
  logic [63:0]  proc_startpc, result;
  logic [0:0]   cur_prog;
  logic [1:0]   pass_mask, timeout_mask, pass_count;

  int vec_cnt = 0;
  int err_cnt = 0;
  int done_cnt = 0;

  // stub processor
  logic [63:0] stub_pc, stub_sp, dmem0, dmem1;
  logic        freeze0;
  always @(posedge CLK) begin
    if (!proc_resetl) begin
      stub_pc <= proc_startpc;
      stub_sp <= proc_startpc;
    end else if (freeze0 && stub_sp == 64'h0)
      stub_pc <= 64'h8;
    else
      stub_pc <= stub_pc + 64'd4;
  end
  assign currentpc = stub_pc;
  assign dmemout   = (stub_sp == 64'h0) ? dmem0 : dmem1;

  always #5 CLK = ~CLK;

  proc_selftest_seq dut (
    .CLK(CLK), .resetl(resetl), .start(start), .abort(abort),
    .start_pcs(start_pcs), .end_pcs(end_pcs), .expected(expected),
    .currentpc(currentpc), .dmemout(dmemout),
    .proc_resetl(proc_resetl), .proc_startpc(proc_startpc),
    .busy(busy), .done(done), .cur_prog(cur_prog),
    .pass_mask(pass_mask), .timeout_mask(timeout_mask),
    .pass_count(pass_count), .all_passed(all_passed), .result(result)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
    if (done) done_cnt++;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (!done && n < bound) begin
      tick();
      n++;
    end
    if (!done) check_val("done_timeout", 64'(done), 64'd1);
  endtask

  task automatic wait_prog1(input int bound);
    int n = 0;
    while (cur_prog != 1'b1 && n < bound) begin
      tick();
      n++;
    end
    if (cur_prog != 1'b1) check_val("prog1_timeout", 64'(cur_prog), 64'd1);
  endtask

  task automatic set_table(input logic [63:0] end0, input logic [63:0] d1);
    start_pcs = {64'h30, 64'h0};
    end_pcs   = {64'h54, end0};
    expected  = {64'h123456789abcdef0, 64'hF};
    dmem0     = 64'hF;
    dmem1     = d1;
  endtask

  initial begin
    int n, d0;
    resetl = 1'b0; start = 1'b0; abort = 1'b0; freeze0 = 1'b0;
    set_table(64'h30, 64'h123456789abcdef0);
    repeat (3) tick();
    check_val("rst_proc_resetl", 64'(proc_resetl), 64'd0);
    check_val("rst_startpc", proc_startpc, 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_masks", {60'd0, pass_mask, timeout_mask}, 64'd0);
    check_val("rst_count", 64'(pass_count), 64'd0);
    check_val("rst_result", result, 64'd0);
    resetl = 1'b1;
    abort = 1'b1; tick(); abort = 1'b0;
    check_val("idle_abort_busy", 64'(busy), 64'd0);
    check_val("idle_abort_done", 64'(done), 64'd0);

    // both programs pass; prog0 hand latency 2 + 13 + 2 = 17
    d0 = done_cnt;
    pulse_start();
    check_val("t1_busy", 64'(busy), 64'd1);
    check_val("t1_proc_resetl", 64'(proc_resetl), 64'd0);
    check_val("t1_startpc0", proc_startpc, 64'h0);
    n = 0;
    while (cur_prog != 1'b1 && n < 100) begin tick(); n++; end
    check_val("t1_latency", 64'(n), 64'd17);
    check_val("t1_startpc1", proc_startpc, 64'h30);
    check_val("t1_prog1_resetl", 64'(proc_resetl), 64'd0);
    wait_done(200);
    check_val("t1_pass_mask", 64'(pass_mask), 64'b11);
    check_val("t1_pass_count", 64'(pass_count), 64'd2);
    check_val("t1_all_passed", 64'(all_passed), 64'd1);
    check_val("t1_done_busy", 64'(busy), 64'd0);
    tick();
    check_val("t1_done_pulses", 64'(done_cnt - d0), 64'd1);
    check_val("t1_hold_mask", 64'(pass_mask), 64'b11);
    check_val("t1_hold_all", 64'(all_passed), 64'd1);

    // prog1 wrong result
    set_table(64'h30, 64'h123456789abcdef1);
    pulse_start();
    wait_done(300);
    check_val("t2_pass_mask", 64'(pass_mask), 64'b01);
    check_val("t2_pass_count", 64'(pass_count), 64'd1);
    check_val("t2_all_passed", 64'(all_passed), 64'd0);
    check_val("t2_result", result, 64'h123456789abcdef1);
    check_val("t2_timeout", 64'(timeout_mask), 64'd0);
    tick();

    // prog0 stuck, watchdog fires
    set_table(64'h30, 64'h123456789abcdef0);
    freeze0 = 1'b1;
    pulse_start();
    wait_done(1000);
    freeze0 = 1'b0;
    check_val("t3_timeout", 64'(timeout_mask), 64'b01);
    check_val("t3_pass_mask", 64'(pass_mask), 64'b10);
    check_val("t3_pass_count", 64'(pass_count), 64'd1);
    tick();

    // end PC reached in the same cycle the watchdog reaches its limit
    set_table(64'h3FC, 64'h123456789abcdef0);
    pulse_start();
    wait_done(1000);
    check_val("t4_timeout", 64'(timeout_mask), 64'b00);
    check_val("t4_pass_mask", 64'(pass_mask), 64'b11);
    tick();

    // start while busy ignored, then abort in prog0 RUN
    set_table(64'h30, 64'h123456789abcdef0);
    d0 = done_cnt;
    pulse_start();
    repeat (4) tick();
    pulse_start();
    check_val("t5_no_restart_resetl", 64'(proc_resetl), 64'd1);
    check_val("t5_no_restart_prog", 64'(cur_prog), 64'd0);
    abort = 1'b1; tick(); abort = 1'b0;
    check_val("t5_abort_done", 64'(done), 64'd1);
    check_val("t5_abort_busy", 64'(busy), 64'd0);
    check_val("t5_abort_mask", 64'(pass_mask), 64'd0);
    tick();
    check_val("t5_done_pulses", 64'(done_cnt - d0), 64'd1);
    check_val("t5_idle_busy", 64'(busy), 64'd0);

    // reset in the middle of prog1 RUN
    d0 = done_cnt;
    pulse_start();
    wait_prog1(100);
    repeat (4) tick();
    check_val("t6_pre_mask", 64'(pass_mask), 64'b01);
    check_val("t6_pre_resetl", 64'(proc_resetl), 64'd1);
    resetl = 1'b0; tick(); resetl = 1'b1;
    check_val("t6_proc_resetl", 64'(proc_resetl), 64'd0);
    check_val("t6_busy", 64'(busy), 64'd0);
    check_val("t6_mask", 64'(pass_mask), 64'd0);
    check_val("t6_count", 64'(pass_count), 64'd0);
    check_val("t6_result", result, 64'd0);
    check_val("t6_prog", 64'(cur_prog), 64'd0);
    repeat (30) tick();
    check_val("t6_no_done", 64'(done_cnt - d0), 64'd0);
    check_val("t6_still_idle", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
